// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multicycle instruction sequencer FSM with memory wait timeout
module multicycle_sequencer #(
  parameter int RETIRE_W    = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [5:0]          opcode,
  input  logic                zero,
  input  logic                bgt,
  input  logic                blt,
  input  logic                mem_ready,
  output logic [2:0]          state,
  output logic                pc_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic                mem_req,
  output logic                mem_we,
  output logic                alu_start,
  output logic [1:0]          pc_src,
  output logic                wb_sel,
  output logic                illegal,
  output logic                bus_err,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t              cur, nxt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                timeout, set_illegal, set_bus_err, retire;
  logic                op_alu, op_bgt, op_blt, op_beq, op_bne, op_jmp, op_call, op_ret, op_lw, op_sw;
  logic                op_branch, op_legal, taken;

  assign op_alu    = (opcode[5:3] == 3'b000);
  assign op_bgt    = (opcode == 6'b001000);
  assign op_blt    = (opcode == 6'b001001);
  assign op_beq    = (opcode == 6'b001010);
  assign op_bne    = (opcode == 6'b001011);
  assign op_jmp    = (opcode == 6'b001100);
  assign op_call   = (opcode == 6'b001101);
  assign op_ret    = (opcode == 6'b001110);
  assign op_lw     = (opcode == 6'b001111);
  assign op_sw     = (opcode == 6'b010000);
  assign op_branch = op_bgt | op_blt | op_beq | op_bne;
  assign op_legal  = op_alu | (opcode[5:3] == 3'b001) | op_sw;
  assign taken     = (op_beq & zero) | (op_bne & ~zero) | (op_blt & blt) | (op_bgt & bgt);

  // The final waiting cycle trips the timeout; a same-cycle mem_ready still wins.
  assign timeout = (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) && !mem_ready;
  assign state   = cur;

  always_comb begin
    nxt         = cur;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    alu_start   = 1'b0;
    pc_src      = 2'b00;
    wb_sel      = 1'b0;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    retire      = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          nxt      = S_DECODE;
        end else if (timeout) begin
          set_bus_err = 1'b1;
          nxt         = S_HALT;
        end
      end
      S_DECODE: begin
        if (!op_legal) begin
          set_illegal = 1'b1;
          nxt         = S_FETCH;
        end else if (op_jmp || op_ret) begin
          pc_write = 1'b1;
          pc_src   = op_ret ? 2'b11 : 2'b01;
          retire   = 1'b1;
          nxt      = S_FETCH;
        end else begin
          nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_start = 1'b1;
        if (op_branch) begin
          pc_write = taken;
          pc_src   = taken ? 2'b10 : 2'b00;
          retire   = 1'b1;
          nxt      = S_FETCH;
        end else if (op_lw || op_sw) begin
          nxt = S_MEM;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = op_sw;
        if (mem_ready) begin
          retire = op_sw;
          nxt    = op_sw ? S_FETCH : S_WB;
        end else if (timeout) begin
          set_bus_err = 1'b1;
          nxt         = S_HALT;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = op_lw | op_call;
        pc_write  = op_call;
        pc_src    = op_call ? 2'b01 : 2'b00;
        retire    = 1'b1;
        nxt       = S_FETCH;
      end
      S_HALT:  nxt = S_HALT;
      default: nxt = S_FETCH;
    endcase
    // Strobes stay quiet while reset is held, even though the reset state is FETCH.
    if (!reset_n) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      alu_start = 1'b0;
      pc_src    = 2'b00;
      wb_sel    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cur      <= S_FETCH;
      wait_cnt <= '0;
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
      retired  <= '0;
    end else begin
      cur <= nxt;
      if (mem_req && !mem_ready && !timeout) wait_cnt <= wait_cnt + WAIT_W'(1);
      else                                   wait_cnt <= '0;
      if (set_illegal) illegal <= 1'b1;
      if (set_bus_err) bus_err <= 1'b1;
      if (retire)      retired <= retired + RETIRE_W'(1);
    end
  end

endmodule
